tdm_demux4: RTL

- Receive-side counterpart to the 4:1 select mux. Takes one serial bit stream carrying four time-division-multiplexed channels (slot order a, b, c, d) and routes each slot to its own output channel register.
- Slot index uses the same 2-bit select encoding as the mux: {x,y} = 00→a, 01→b, 10→c, 11→d.
- Frame alignment comes from an fsync strobe. A flywheel tolerates occasional missing syncs.
- Sits at the far end of a serial link, after bit-rate recovery; bit_en marks valid bit times.

---
 rtl/tdm_pkg.sv | 30 +++
 rtl/tdm_slot_timer.sv | 73 +++++++
 rtl/tdm_demux4.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-channel TDM demultiplexer: slot/select encoding,
// receiver states and the command set the top uses to drive the slot timer.
package tdm_pkg;

   typedef enum logic [1:0] {
      SLOT_A = 2'b00,
      SLOT_B = 2'b01,
      SLOT_C = 2'b10,
      SLOT_D = 2'b11
   } slot_e;

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_SYNC = 1'b1
   } state_e;

   typedef enum logic [2:0] {
      TMR_HOLD      = 3'd0,
      TMR_CLEAR     = 3'd1,
      TMR_RESTART   = 3'd2,
      TMR_STEP      = 3'd3,
      TMR_STEP_SYNC = 3'd4,
      TMR_STEP_MISS = 3'd5
   } tmr_cmd_e;

   function automatic logic [3:0] slot_onehot(input logic [1:0] slot);
      return 4'b0001 << slot;
   endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// Bit/slot position and missed-sync counting for the TDM receiver; the top
// decides what happens each bit time and issues one command per edge.
module tdm_slot_timer
   import tdm_pkg::*;
#(
   parameter int SLOT_BITS = 8,
   parameter int MAX_MISS  = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] cmd,
   output logic [1:0] slot,
   output logic       last_bit,
   output logic       boundary,
   output logic       miss_limit
);

   localparam int CW = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
   localparam int MW = $clog2(MAX_MISS + 1);

   logic [CW-1:0] bit_cnt_r;
   logic [1:0]    slot_r;
   logic [MW-1:0] miss_r;

   assign slot       = slot_r;
   assign last_bit   = (bit_cnt_r == CW'(SLOT_BITS - 1));
   assign boundary   = (slot_r == 2'b00) && (bit_cnt_r == {CW{1'b0}});
   // Asserted when one more missed boundary would exhaust the flywheel.
   assign miss_limit = (miss_r == MW'(MAX_MISS - 1));

   // Position and miss counters, advanced only on commanded bit times.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt_r <= {CW{1'b0}};
         slot_r    <= 2'b00;
         miss_r    <= {MW{1'b0}};
      end else begin
         case (cmd)
            TMR_CLEAR: begin
               bit_cnt_r <= {CW{1'b0}};
               slot_r    <= 2'b00;
               miss_r    <= {MW{1'b0}};
            end
            TMR_RESTART: begin
               bit_cnt_r <= CW'(1);
               slot_r    <= 2'b00;
               miss_r    <= {MW{1'b0}};
            end
            TMR_STEP, TMR_STEP_SYNC, TMR_STEP_MISS: begin
               if (last_bit) begin
                  bit_cnt_r <= {CW{1'b0}};
                  slot_r    <= slot_r + 2'd1;
               end else begin
                  bit_cnt_r <= bit_cnt_r + CW'(1);
               end
               if (cmd == TMR_STEP_SYNC) begin
                  miss_r <= {MW{1'b0}};
               end else if (cmd == TMR_STEP_MISS) begin
                  miss_r <= miss_r + MW'(1);
               end else begin
                  miss_r <= miss_r;
               end
            end
            default: begin
               bit_cnt_r <= bit_cnt_r;
               slot_r    <= slot_r;
               miss_r    <= miss_r;
            end
         endcase
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// Receive-side 4-channel TDM demultiplexer: frame lock FSM with flywheel,
// serial-to-parallel shift register and per-channel word registers.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int SLOT_BITS = 8,
   parameter int MAX_MISS  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 bit_en,
   input  logic                 din,
   input  logic                 fsync,
   output logic [SLOT_BITS-1:0] a,
   output logic [SLOT_BITS-1:0] b,
   output logic [SLOT_BITS-1:0] c,
   output logic [SLOT_BITS-1:0] d,
   output logic [3:0]           ch_valid,
   output logic                 frame_valid,
   output logic [1:0]           sel,
   output logic                 locked,
   output logic                 sync_err
);

   state_e               state_r;
   state_e               state_n;
   logic [2:0]           cmd_s;
   logic                 shift_en_s;
   logic                 load_en_s;
   logic                 realign_s;
   logic [1:0]           slot_s;
   logic                 last_bit_s;
   logic                 boundary_s;
   logic                 miss_limit_s;
   logic [SLOT_BITS-1:0] shift_r;
   logic [SLOT_BITS-1:0] word_s;

   tdm_slot_timer #(
      .SLOT_BITS (SLOT_BITS),
      .MAX_MISS  (MAX_MISS)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (cmd_s),
      .slot       (slot_s),
      .last_bit   (last_bit_s),
      .boundary   (boundary_s),
      .miss_limit (miss_limit_s)
   );

   assign word_s = {shift_r[SLOT_BITS-2:0], din};
   assign sel    = slot_s;

   // Lock FSM: decides per bit time whether to decode, realign or drop lock.
   always_comb begin
      state_n    = state_r;
      cmd_s      = TMR_HOLD;
      shift_en_s = 1'b0;
      load_en_s  = 1'b0;
      realign_s  = 1'b0;
      if (bit_en) begin
         case (state_r)
            ST_HUNT: begin
               if (fsync) begin
                  state_n    = ST_SYNC;
                  cmd_s      = TMR_RESTART;
                  shift_en_s = 1'b1;
               end else begin
                  cmd_s = TMR_HOLD;
               end
            end
            ST_SYNC: begin
               if (fsync && !boundary_s) begin
                  // Unexpected sync wins: this bit restarts the frame.
                  cmd_s      = TMR_RESTART;
                  shift_en_s = 1'b1;
                  realign_s  = 1'b1;
               end else if (boundary_s && !fsync) begin
                  if (miss_limit_s) begin
                     state_n = ST_HUNT;
                     cmd_s   = TMR_CLEAR;
                  end else begin
                     cmd_s      = TMR_STEP_MISS;
                     shift_en_s = 1'b1;
                  end
               end else if (boundary_s) begin
                  cmd_s      = TMR_STEP_SYNC;
                  shift_en_s = 1'b1;
               end else begin
                  cmd_s      = TMR_STEP;
                  shift_en_s = 1'b1;
                  load_en_s  = last_bit_s;
               end
            end
            default: begin
               state_n = ST_HUNT;
               cmd_s   = TMR_CLEAR;
            end
         endcase
      end else begin
         state_n = state_r;
      end
   end

   // State, shift register, channel words and single-cycle status pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_HUNT;
         locked      <= 1'b0;
         shift_r     <= {SLOT_BITS{1'b0}};
         a           <= {SLOT_BITS{1'b0}};
         b           <= {SLOT_BITS{1'b0}};
         c           <= {SLOT_BITS{1'b0}};
         d           <= {SLOT_BITS{1'b0}};
         ch_valid    <= 4'b0000;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         state_r     <= state_n;
         locked      <= (state_n == ST_SYNC);
         ch_valid    <= load_en_s ? slot_onehot(slot_s) : 4'b0000;
         frame_valid <= load_en_s && (slot_s == SLOT_D);
         sync_err    <= realign_s;
         if (shift_en_s) begin
            shift_r <= word_s;
         end else begin
            shift_r <= shift_r;
         end
         if (load_en_s) begin
            case (slot_s)
               SLOT_A:  a <= word_s;
               SLOT_B:  b <= word_s;
               SLOT_C:  c <= word_s;
               SLOT_D:  d <= word_s;
               default: a <= a;
            endcase
         end else begin
            a <= a;
         end
      end
   end

endmodule
